// File: rtl/cma_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cma_ctrl_pkg
// Shared constants for the CMA adaptation sequencer: datapath widths, state
// encodings, warm-up / window terminal counts and the saturating magnitude
// helper used by the divergence monitor.
// -----------------------------------------------------------------------------
package cma_ctrl_pkg;

    localparam int FIR_LEN      = 21;
    localparam int NB_OUT       = 18;
    localparam int NB_MU        = 16;
    localparam int NB_CNT       = 20;
    localparam int WIN_LEN      = 256;
    // Sample-line alignment plus FIR pipeline latency beyond the tap count.
    localparam int WARMUP_EXTRA = 2;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_CLEAR  = 3'd1;
    localparam logic [ST_W-1:0] ST_WARMUP = 3'd2;
    localparam logic [ST_W-1:0] ST_ACQ    = 3'd3;
    localparam logic [ST_W-1:0] ST_TRACK  = 3'd4;
    localparam logic [ST_W-1:0] ST_FREEZE = 3'd5;

    // Counter values at which the last sample of a phase is being consumed.
    localparam logic [NB_CNT-1:0] WARM_LAST = NB_CNT'(FIR_LEN + WARMUP_EXTRA - 1);
    localparam logic [NB_CNT-1:0] WIN_LAST  = NB_CNT'(WIN_LEN - 1);

    // |x| clipped to NB_OUT-1 bits; the most negative code maps to full scale.
    function automatic logic [NB_OUT-2:0] sat_mag(input logic signed [NB_OUT-1:0] x);
        logic signed [NB_OUT-1:0] neg_v;
        neg_v = -x;
        if (x == {1'b1, {(NB_OUT-1){1'b0}}}) begin
            return {(NB_OUT-1){1'b1}};
        end else if (x[NB_OUT-1]) begin
            return neg_v[NB_OUT-2:0];
        end else begin
            return x[NB_OUT-2:0];
        end
    endfunction

endpackage

// File: rtl/cma_adapt_ctrl_if.sv
// -----------------------------------------------------------------------------
// cma_adapt_ctrl_if
// Control/status bundle between the equalizer host and the adaptation
// sequencer.
//   master : drives commands, levels and tuning inputs (i_*), observes o_*.
//   slave  : the sequencer; consumes i_*, drives o_en/o_mu/o_coeff_clear/
//            o_diverged/o_state.
// -----------------------------------------------------------------------------
interface cma_adapt_ctrl_if
    import cma_ctrl_pkg::*;
();

    logic                     i_start;
    logic                     i_stop;
    logic                     i_freeze;
    logic                     i_valid;
    logic signed [NB_OUT-1:0] i_fir_out;
    logic [NB_MU-1:0]         i_mu_acq;
    logic [NB_MU-1:0]         i_mu_track;
    logic [NB_CNT-1:0]        i_gear_len;
    logic [NB_OUT-2:0]        i_sat_thr;
    logic [NB_CNT-1:0]        i_div_max;

    logic                     o_en;
    logic [NB_MU-1:0]         o_mu;
    logic                     o_coeff_clear;
    logic                     o_diverged;
    logic [ST_W-1:0]          o_state;

    modport master (
        output i_start, i_stop, i_freeze, i_valid, i_fir_out,
               i_mu_acq, i_mu_track, i_gear_len, i_sat_thr, i_div_max,
        input  o_en, o_mu, o_coeff_clear, o_diverged, o_state
    );

    modport slave (
        input  i_start, i_stop, i_freeze, i_valid, i_fir_out,
               i_mu_acq, i_mu_track, i_gear_len, i_sat_thr, i_div_max,
        output o_en, o_mu, o_coeff_clear, o_diverged, o_state
    );

endinterface

// File: rtl/cma_div_monitor.sv
// -----------------------------------------------------------------------------
// cma_div_monitor
// Counts saturated FIR output samples over fixed windows of WIN_LEN valid
// samples and flags divergence when a window ends with too many of them.
// Ports:
//   i_clock, i_reset : clock, async active-high reset
//   clr              : synchronous clear of both counters
//   en               : monitor active (tracking)
//   hold             : freeze counters (divergence is still evaluated)
//   valid, fir_out   : sample strobe and signed FIR output
//   sat_thr, div_max : magnitude threshold and tolerated saturations/window
//   diverge          : combinational; high on the terminal sample of a bad window
// -----------------------------------------------------------------------------
module cma_div_monitor
    import cma_ctrl_pkg::*;
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     hold,
    input  logic                     valid,
    input  logic signed [NB_OUT-1:0] fir_out,
    input  logic [NB_OUT-2:0]        sat_thr,
    input  logic [NB_CNT-1:0]        div_max,
    output logic                     diverge
);

    logic [NB_CNT-1:0] win_cnt_r;
    logic [NB_CNT-1:0] sat_cnt_r;
    logic [NB_OUT-2:0] mag_s;
    logic              sat_s;
    logic              term_s;
    logic [NB_CNT-1:0] sat_tot_s;

    assign mag_s     = sat_mag(fir_out);
    assign sat_s     = (mag_s > sat_thr);
    assign term_s    = (win_cnt_r == WIN_LAST);
    // The terminal sample itself is included in the window's tally.
    assign sat_tot_s = sat_cnt_r + {{(NB_CNT-1){1'b0}}, sat_s};
    // Not gated by hold, so a restart still wins over a simultaneous freeze.
    assign diverge   = en & valid & term_s & (sat_tot_s > div_max);

    // Window and saturation counters; cleared at window end, frozen on hold.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            win_cnt_r <= {NB_CNT{1'b0}};
            sat_cnt_r <= {NB_CNT{1'b0}};
        end else if (clr) begin
            win_cnt_r <= {NB_CNT{1'b0}};
            sat_cnt_r <= {NB_CNT{1'b0}};
        end else if (en && valid && !hold) begin
            if (term_s) begin
                win_cnt_r <= {NB_CNT{1'b0}};
                sat_cnt_r <= {NB_CNT{1'b0}};
            end else begin
                win_cnt_r <= win_cnt_r + NB_CNT'(1);
                sat_cnt_r <= sat_tot_s;
            end
        end else begin
            win_cnt_r <= win_cnt_r;
            sat_cnt_r <= sat_cnt_r;
        end
    end

endmodule

// File: rtl/cma_adapt_ctrl.sv
// -----------------------------------------------------------------------------
// cma_adapt_ctrl
// Adaptation sequencer for the CMA FFE: clears coefficients, waits for the
// sample line and FIR pipeline to fill, runs a mu-halving acquisition
// schedule, then tracks with a fixed mu under a divergence watchdog.
// Ports:
//   i_clock, i_reset : clock, async active-high reset
//   bus (slave)      : i_start/i_stop/i_freeze/i_valid/i_fir_out and tuning
//                      inputs in; o_en/o_mu/o_coeff_clear/o_diverged/o_state
//                      out, all registered.
// -----------------------------------------------------------------------------
module cma_adapt_ctrl
    import cma_ctrl_pkg::*;
(
    input  logic            i_clock,
    input  logic            i_reset,
    cma_adapt_ctrl_if.slave bus
);

    logic [ST_W-1:0]   state_r,  state_nxt_s;
    logic [ST_W-1:0]   ret_r,    ret_nxt_s;
    logic [NB_MU-1:0]  mu_r,     mu_nxt_s;
    logic [NB_MU-1:0]  track_r,  track_nxt_s;
    logic [NB_CNT-1:0] warm_r,   warm_nxt_s;
    logic [NB_CNT-1:0] gear_r,   gear_nxt_s;

    logic              en_r,     en_nxt_s;
    logic [NB_MU-1:0]  mu_out_r, mu_out_nxt_s;
    logic              clear_r;
    logic              div_r,    div_take_s;

    logic [NB_CNT-1:0] gear_lim_s;
    logic              gear_hit_s;
    logic              warm_hit_s;
    logic [NB_MU-1:0]  mu_half_s;
    logic              mon_div_s;
    logic              mon_clr_s;
    logic              mon_en_s;

    // A gear length of zero behaves as one sample per gear step.
    assign gear_lim_s = (bus.i_gear_len == {NB_CNT{1'b0}}) ? NB_CNT'(1) : bus.i_gear_len;
    assign gear_hit_s = (({1'b0, gear_r} + (NB_CNT+1)'(1)) >= {1'b0, gear_lim_s});
    assign warm_hit_s = (warm_r == WARM_LAST);
    assign mu_half_s  = mu_r >> 1;

    // Window counters live only through TRACK and FREEZE; any other state
    // (including TRACK entry from ACQ) starts them from zero.
    assign mon_clr_s  = !((state_r == ST_TRACK) || (state_r == ST_FREEZE));
    assign mon_en_s   = (state_r == ST_TRACK);

    cma_div_monitor u_div_monitor (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clr     (mon_clr_s),
        .en      (mon_en_s),
        .hold    (bus.i_freeze),
        .valid   (bus.i_valid),
        .fir_out (bus.i_fir_out),
        .sat_thr (bus.i_sat_thr),
        .div_max (bus.i_div_max),
        .diverge (mon_div_s)
    );

    // Next-state, gear schedule and warm-up counting.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        mu_nxt_s    = mu_r;
        track_nxt_s = track_r;
        warm_nxt_s  = warm_r;
        gear_nxt_s  = gear_r;
        div_take_s  = 1'b0;
        if (bus.i_stop) begin
            state_nxt_s = ST_IDLE;
            warm_nxt_s  = {NB_CNT{1'b0}};
            gear_nxt_s  = {NB_CNT{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    state_nxt_s = ST_WARMUP;
                    warm_nxt_s  = {NB_CNT{1'b0}};
                    gear_nxt_s  = {NB_CNT{1'b0}};
                end
                ST_WARMUP: begin
                    if (bus.i_valid && warm_hit_s) begin
                        state_nxt_s = ST_ACQ;
                        mu_nxt_s    = bus.i_mu_acq;
                        track_nxt_s = bus.i_mu_track;
                        warm_nxt_s  = {NB_CNT{1'b0}};
                        gear_nxt_s  = {NB_CNT{1'b0}};
                    end else if (bus.i_valid) begin
                        warm_nxt_s  = warm_r + NB_CNT'(1);
                    end else begin
                        warm_nxt_s  = warm_r;
                    end
                end
                ST_ACQ: begin
                    if (bus.i_freeze) begin
                        state_nxt_s = ST_FREEZE;
                        ret_nxt_s   = ST_ACQ;
                    end else if (bus.i_valid && gear_hit_s) begin
                        gear_nxt_s = {NB_CNT{1'b0}};
                        // Next halving would reach the floor: settle on it.
                        if (mu_half_s <= track_r) begin
                            state_nxt_s = ST_TRACK;
                            mu_nxt_s    = track_r;
                        end else begin
                            mu_nxt_s    = mu_half_s;
                        end
                    end else if (bus.i_valid) begin
                        gear_nxt_s = gear_r + NB_CNT'(1);
                    end else begin
                        gear_nxt_s = gear_r;
                    end
                end
                ST_TRACK: begin
                    if (mon_div_s) begin
                        state_nxt_s = ST_CLEAR;
                        div_take_s  = 1'b1;
                    end else if (bus.i_freeze) begin
                        state_nxt_s = ST_FREEZE;
                        ret_nxt_s   = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_TRACK;
                    end
                end
                ST_FREEZE: begin
                    if (!bus.i_freeze) begin
                        state_nxt_s = ret_r;
                    end else begin
                        state_nxt_s = ST_FREEZE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output values as they will appear once the next state is registered.
    always_comb begin
        en_nxt_s = (state_nxt_s == ST_WARMUP) || (state_nxt_s == ST_ACQ) ||
                   (state_nxt_s == ST_TRACK)  || (state_nxt_s == ST_FREEZE);
        case (state_nxt_s)
            ST_ACQ:   mu_out_nxt_s = mu_nxt_s;
            ST_TRACK: mu_out_nxt_s = track_nxt_s;
            default:  mu_out_nxt_s = {NB_MU{1'b0}};
        endcase
    end

    // State, schedule registers and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            ret_r    <= ST_IDLE;
            mu_r     <= {NB_MU{1'b0}};
            track_r  <= {NB_MU{1'b0}};
            warm_r   <= {NB_CNT{1'b0}};
            gear_r   <= {NB_CNT{1'b0}};
            en_r     <= 1'b0;
            mu_out_r <= {NB_MU{1'b0}};
            clear_r  <= 1'b0;
            div_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ret_r    <= ret_nxt_s;
            mu_r     <= mu_nxt_s;
            track_r  <= track_nxt_s;
            warm_r   <= warm_nxt_s;
            gear_r   <= gear_nxt_s;
            en_r     <= en_nxt_s;
            mu_out_r <= mu_out_nxt_s;
            clear_r  <= (state_nxt_s == ST_CLEAR);
            div_r    <= div_take_s;
        end
    end

    assign bus.o_en          = en_r;
    assign bus.o_mu          = mu_out_r;
    assign bus.o_coeff_clear = clear_r;
    assign bus.o_diverged    = div_r;
    assign bus.o_state       = state_r;

endmodule

// File: tb/tb_cma_adapt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cma_adapt_ctrl
// Directed bench for the CMA adaptation sequencer. Inputs change 1 time unit
// after a rising edge; outputs are checked at the same point, so each check
// sees the registers updated by the preceding edge.
// -----------------------------------------------------------------------------
module tb_cma_adapt_ctrl;
    import cma_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic div_seen;

    cma_adapt_ctrl_if bus_if ();

    cma_adapt_ctrl dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_if)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic [15:0] mu);
        chk({tag, ".state"}, 32'(bus_if.o_state), 32'(st));
        chk({tag, ".mu"},    32'(bus_if.o_mu),    32'(mu));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid sample followed by one idle cycle.
    task automatic vs();
        bus_if.i_valid = 1'b1;
        tick();
        bus_if.i_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.i_start     = 1'b0;
        bus_if.i_stop      = 1'b0;
        bus_if.i_freeze    = 1'b0;
        bus_if.i_valid     = 1'b0;
        bus_if.i_fir_out   = 18'sd0;
        bus_if.i_mu_acq    = 16'h4000;
        bus_if.i_mu_track  = 16'h0800;
        bus_if.i_gear_len  = 20'd4;
        bus_if.i_sat_thr   = 17'h1FFFF;
        bus_if.i_div_max   = 20'd10;
        div_seen           = 1'b0;

        // Reset state.
        repeat (2) tick();
        chk_st("reset", 3'd0, 16'h0000);
        chk("reset.en",  32'(bus_if.o_en), 32'd0);
        chk("reset.clr", 32'(bus_if.o_coeff_clear), 32'd0);
        chk("reset.div", 32'(bus_if.o_diverged), 32'd0);
        rst = 1'b0;
        tick();
        chk_st("idle", 3'd0, 16'h0000);

        // Start: one-cycle clear, then warm-up.
        bus_if.i_start = 1'b1;
        tick();
        bus_if.i_start = 1'b0;
        chk("start.clr", 32'(bus_if.o_coeff_clear), 32'd1);
        chk_st("start", 3'd1, 16'h0000);
        tick();
        chk("warm.clr", 32'(bus_if.o_coeff_clear), 32'd0);
        chk("warm.en",  32'(bus_if.o_en), 32'd1);
        chk_st("warm0", 3'd2, 16'h0000);

        // 22 valid samples keep WARMUP, the 23rd enters ACQ.
        repeat (22) vs();
        chk_st("warm22", 3'd2, 16'h0000);
        vs();
        chk_st("acq_entry", 3'd3, 16'h4000);

        // Gear schedule, gear_len=4.
        repeat (3) vs();
        chk_st("gear3", 3'd3, 16'h4000);
        vs();
        chk_st("gear4", 3'd3, 16'h2000);
        repeat (2) vs();
        chk_st("gear6", 3'd3, 16'h2000);

        // Freeze for 10 cycles; valid samples during freeze are not counted.
        bus_if.i_freeze = 1'b1;
        tick();
        chk_st("frz_in", 3'd5, 16'h0000);
        chk("frz.en", 32'(bus_if.o_en), 32'd1);
        bus_if.i_valid = 1'b1;
        repeat (9) tick();
        bus_if.i_valid = 1'b0;
        chk_st("frz_hold", 3'd5, 16'h0000);
        bus_if.i_freeze = 1'b0;
        tick();
        chk_st("frz_out", 3'd3, 16'h2000);
        vs();
        chk_st("gear7", 3'd3, 16'h2000);
        vs();
        chk_st("gear8", 3'd3, 16'h1000);
        repeat (3) vs();
        chk_st("gear11", 3'd3, 16'h1000);
        vs();
        chk_st("track_in", 3'd4, 16'h0800);

        // Window with exactly i_div_max saturated samples, last one on the
        // terminal sample: no restart.
        bus_if.i_sat_thr = 17'h10000;
        bus_if.i_valid   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus_if.i_fir_out = (i >= 246) ? 18'sh20000 : 18'sd0;
            tick();
            div_seen = div_seen | bus_if.o_diverged;
        end
        bus_if.i_valid   = 1'b0;
        bus_if.i_fir_out = 18'sd0;
        chk("win10.div_seen", 32'(div_seen), 32'd0);
        chk_st("win10", 3'd4, 16'h0800);
        tick();

        // Window with i_div_max+1 saturated samples: restart on the last one.
        bus_if.i_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            bus_if.i_fir_out = (i >= 245) ? 18'sh20000 : 18'sd0;
            tick();
            div_seen = div_seen | bus_if.o_diverged;
        end
        chk("win11.pre_div", 32'(div_seen), 32'd0);
        chk_st("win11.pre", 3'd4, 16'h0800);
        bus_if.i_fir_out = 18'sh20000;
        tick();
        bus_if.i_valid   = 1'b0;
        bus_if.i_fir_out = 18'sd0;
        chk("div.pulse", 32'(bus_if.o_diverged), 32'd1);
        chk("div.clr",   32'(bus_if.o_coeff_clear), 32'd1);
        chk_st("div", 3'd1, 16'h0000);
        tick();
        chk("div.pulse_end", 32'(bus_if.o_diverged), 32'd0);
        chk("div.clr_end",   32'(bus_if.o_coeff_clear), 32'd0);
        chk_st("div.rewarm", 3'd2, 16'h0000);

        // Re-acquire with gear_len=0 (one sample per gear step).
        bus_if.i_gear_len = 20'd0;
        repeat (23) vs();
        chk_st("reacq", 3'd3, 16'h4000);
        vs();
        chk_st("g0_1", 3'd3, 16'h2000);
        vs();
        chk_st("g0_2", 3'd3, 16'h1000);
        vs();
        chk_st("g0_3", 3'd4, 16'h0800);

        // Stop in TRACK with a simultaneous start.
        bus_if.i_stop  = 1'b1;
        bus_if.i_start = 1'b1;
        tick();
        bus_if.i_stop  = 1'b0;
        bus_if.i_start = 1'b0;
        chk_st("stop", 3'd0, 16'h0000);
        chk("stop.en",  32'(bus_if.o_en), 32'd0);
        chk("stop.clr", 32'(bus_if.o_coeff_clear), 32'd0);
        tick();
        chk_st("stop.idle", 3'd0, 16'h0000);

        // mu_acq below mu_track: first gear event lands in TRACK.
        bus_if.i_mu_acq   = 16'h0400;
        bus_if.i_gear_len = 20'd2;
        bus_if.i_start    = 1'b1;
        tick();
        bus_if.i_start    = 1'b0;
        tick();
        repeat (23) vs();
        chk_st("low.acq", 3'd3, 16'h0400);
        vs();
        chk_st("low.g1", 3'd3, 16'h0400);
        vs();
        chk_st("low.track", 3'd4, 16'h0800);

        // Asynchronous reset in the middle of ACQ.
        bus_if.i_stop = 1'b1;
        tick();
        bus_if.i_stop     = 1'b0;
        bus_if.i_mu_acq   = 16'h4000;
        bus_if.i_gear_len = 20'd4;
        bus_if.i_start    = 1'b1;
        tick();
        bus_if.i_start    = 1'b0;
        tick();
        repeat (23) vs();
        chk_st("pre_rst", 3'd3, 16'h4000);
        #2;
        rst = 1'b1;
        #1;
        chk_st("async_rst", 3'd0, 16'h0000);
        chk("async_rst.en",  32'(bus_if.o_en), 32'd0);
        chk("async_rst.clr", 32'(bus_if.o_coeff_clear), 32'd0);
        chk("async_rst.div", 32'(bus_if.o_diverged), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_st("post_rst", 3'd0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cma_adapt_ctrl.md
# cma_adapt_ctrl

Adaptation sequencer for the CMA feed-forward equalizer. It drives the FFE sample-line enable and the CMA step size, and requests coefficient clears. After a start command it clears the weights and waits for the sample line and FIR pipeline to fill. It then runs a gear-shifted acquisition schedule (halving mu), settles into tracking mu, and supports freeze and stop. A divergence monitor on the FIR output restarts adaptation when the output saturates too often.

## Interface
- FIR_LEN, 21, FFE taps; sets warm-up length.
- NB_OUT, 18, FIR output width (signed).
- NB_MU, 16, step-size width (unsigned).
- NB_CNT, 20, width of all sample counters and length inputs.
- WIN_LEN, 256, divergence window length in valid samples.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_start  in  1  start pulse; honoured in IDLE only.
- i_stop  in  1  stop pulse; highest priority, any state.
- i_freeze  in  1  level; holds adaptation while high.
- i_valid  in  1  input sample strobe, same as the FFE strobe.
- i_fir_out  in  NB_OUT  signed FIR output.
- i_mu_acq  in  NB_MU  initial acquisition mu; sampled on WARMUP exit.
- i_mu_track  in  NB_MU  tracking mu, also the gear floor; sampled on WARMUP exit.
- i_gear_len  in  NB_CNT  valid samples per gear step; 0 is treated as 1.
- i_sat_thr  in  NB_OUT-1  unsigned saturation threshold on the magnitude of i_fir_out.
- i_div_max  in  NB_CNT  maximum tolerated saturated samples per window.
- o_en  out  1  FFE sample-line enable.
- o_mu  out  NB_MU  step size to the CMA update.
- o_coeff_clear  out  1  one-cycle pulse; reinitialises the weight memory.
- o_diverged  out  1  one-cycle pulse on a divergence restart.
- o_state  out  3  current state encoding.

## Operation
States and encoding: IDLE=0, CLEAR=1, WARMUP=2, ACQ=3, TRACK=4, FREEZE=5.
- Transition priority: i_stop > divergence > i_freeze > normal.
- **IDLE:** o_en=0, o_mu=0. i_start → CLEAR.
- **CLEAR:** exactly one cycle, o_coeff_clear=1. All counters cleared. → WARMUP.
- **WARMUP:**
  - o_en=1, o_mu=0. Counts i_valid.
  - On the (FIR_LEN+2)-th valid sample (23 by default): mu_reg←i_mu_acq, track_reg←i_mu_track, → ACQ.
- **ACQ:**
  - o_mu=mu_reg. gear_cnt counts valid samples.
  - On reaching max(i_gear_len,1): if (mu_reg>>1) ≤ track_reg, then mu_reg←track_reg and → TRACK.
  - Otherwise mu_reg←mu_reg>>1 and gear_cnt←0.
  - If i_mu_acq ≤ i_mu_track, the first gear event enters TRACK.
- **TRACK:**
  - o_mu=track_reg. Divergence monitor active.
  - win_cnt and sat_cnt are cleared on TRACK entry.
  - Each valid sample increments win_cnt, and increments sat_cnt if |i_fir_out| > i_sat_thr.
  - |−2^(NB_OUT−1)| saturates to 2^(NB_OUT−1)−1.
  - On the WIN_LEN-th valid sample, the final sat count includes that sample:
    - count > i_div_max: o_diverged pulse → CLEAR.
    - otherwise: both counters reset and tracking continues.
- **FREEZE:**
  - Entered from ACQ/TRACK while i_freeze=1; the return state is stored.
  - o_en=1, o_mu=0. gear, win and sat counters hold; no divergence check.
  - When i_freeze=0, return to the stored state with mu_reg and counters unchanged.
- **i_stop:** from any non-IDLE state → IDLE. Counters cleared, no clear pulse.
- **Counter wrap:** counters never wrap; each is cleared at its terminal event.

## Timing
- All outputs are registered. State, o_mu, o_en and pulses update on the edge that consumes the causing input; visible the following cycle.
- Reset values: state IDLE, o_en=0, o_mu=0, o_coeff_clear=0, o_diverged=0, o_state=0. All internal counters and registers are 0.
- Reset mid-operation aborts immediately to IDLE. No clear pulse is emitted.
- Start-to-clear latency: i_start at edge n → o_coeff_clear high in cycle n+1 → WARMUP at n+2.
- Simultaneous events:
  - i_start outside IDLE is ignored.
  - i_freeze high in the same cycle as a gear or window terminal event: the terminal event is not taken, and the counters hold at their terminal value.
  - Divergence in the same cycle as i_freeze: restart wins.
- i_valid gaps stall all counting. Non-valid cycles never advance counters.

## Structure
- Package cma_ctrl_pkg:
  - state localparams and width;
  - WARMUP_EXTRA=2 (pipeline/alignment latency beyond FIR_LEN).
- Sub-module cma_div_monitor: magnitude, threshold compare, window/sat counters, clear/hold inputs, diverge output.
- FSM and gear logic live in cma_adapt_ctrl.

## Test plan
- **Reset values:** assert i_reset mid-ACQ → all outputs 0 and o_state=0, asynchronously, with no clock edge needed.
- **Start and warm-up:** i_start, then valid every other cycle → one-cycle o_coeff_clear. o_mu=0 for 23 valid samples. ACQ entered with o_mu=0x4000.
- **Gear shift:** mu_acq=0x4000, mu_track=0x0800, gear_len=4 → o_mu 0x4000, 0x2000, 0x1000, then 0x0800 with o_state=4 after the 12th ACQ valid sample.
- **Freeze:** i_freeze high for 10 cycles after 2 ACQ samples at 0x2000 → o_mu=0 and o_state=5. Returns to 0x2000, and the shift occurs 2 valid samples later.
- **Divergence:** TRACK with WIN_LEN=256, i_div_max=10, i_sat_thr=0x10000, 11 samples of i_fir_out=−131072 in the window → o_diverged and o_coeff_clear pulses, o_state=1 → 2. With 10 such samples there is no restart.
- **Stop and start in TRACK:** i_stop in TRACK → IDLE with o_en=0 next cycle. A simultaneous i_start is ignored.
